// File: rtl/imem_boot_loader.sv
// imem_boot_loader: synthesizable instruction-memory boot path for the
// single-cycle RISC-V core.
//
// Sequence on start:
//   1. Optionally FILL the whole IM with NOP_WORD, one word per cycle.
//   2. LOAD program words from a valid/ready stream into consecutive
//      addresses, starting at base_addr.
//   3. DRAIN the last registered write.
//   4. Enter DONE and release the core reset.
//
// All IM write-port signals and status flags are registered.
module imem_boot_loader #(
  parameter int              XLEN         = 32,
  parameter int              ADDR_W       = 10,
  parameter int              FILL_ON_BOOT = 1,
  parameter logic [XLEN-1:0] NOP_WORD     = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              s_valid,
  input  logic [XLEN-1:0]   s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [XLEN-1:0]   im_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count,
  output logic [XLEN-1:0]   checksum
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [XLEN-1:0]     r_wdata;
  logic                r_core_rst;
  logic                r_ready;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [ADDR_W:0]     r_wcnt;
  logic [XLEN-1:0]     r_csum;

  logic                w_hs;
  logic                w_final;

  // Wrapping checksum accumulate; any carry out of XLEN is discarded.
  function automatic logic [XLEN-1:0] f_csum_add(input logic [XLEN-1:0] acc,
                                                 input logic [XLEN-1:0] word);
    f_csum_add = acc + word;
  endfunction

  // Handshake and end-of-image detection for the current LOAD beat.
  // A word accepted at the top address ends the image even without s_last,
  // so the pointer never wraps back into low memory.
  always_comb begin
    w_hs    = s_valid & r_ready;
    w_final = s_last | (r_ptr == LAST_ADDR);
  end

  // Boot sequencer: a single FSM with every output registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_core_rst <= 1'b1;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_wcnt     <= '0;
      r_csum     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_err      <= 1'b0;
            r_wcnt     <= '0;
            r_csum     <= '0;
            r_ptr      <= base_addr;
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
            r_busy     <= 1'b1;
            if (FILL_ON_BOOT != 0) begin
              r_state <= S_FILL;
              r_we    <= 1'b1;
              r_addr  <= '0;
              r_wdata <= NOP_WORD;
            end else begin
              r_state <= S_LOAD;
              r_ready <= 1'b1;
            end
          end
        end

        S_FILL: begin
          // r_addr is the fill cursor; the write at LAST_ADDR is the final one.
          if (r_addr == LAST_ADDR) begin
            r_we    <= 1'b0;
            r_state <= S_LOAD;
            r_ready <= 1'b1;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end

        S_LOAD: begin
          r_we <= w_hs;
          if (w_hs) begin
            r_addr  <= r_ptr;
            r_wdata <= s_data;
            r_wcnt  <= r_wcnt + 1'b1;
            r_csum  <= f_csum_add(r_csum, s_data);
            if (w_final) begin
              r_ready <= 1'b0;
              r_state <= S_DRAIN;
              r_err   <= ~s_last;
            end else begin
              r_ptr <= r_ptr + 1'b1;
            end
          end
        end

        S_DRAIN: begin
          // The last word is on the write port this cycle; the core is
          // released only once that write has landed.
          r_we       <= 1'b0;
          r_state    <= S_DONE;
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_core_rst <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Drive the ports from the registered state.
  always_comb begin
    s_ready    = r_ready;
    im_we      = r_we;
    im_addr    = r_addr;
    im_wdata   = r_wdata;
    core_rst   = r_core_rst;
    busy       = r_busy;
    done       = r_done;
    err        = r_err;
    word_count = r_wcnt;
    checksum   = r_csum;
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed and randomized bench for imem_boot_loader.
//
// Two instances share one clock and one input stream:
//   u_fill   - FILL_ON_BOOT = 1
//   u_nofill - FILL_ON_BOOT = 0
//
// Expected IM contents, counts, checksum and err come from a word-level
// model of the boot rules, applied to arrays inside the bench.
module tb_imem_boot_loader;

  localparam int          AW    = 10;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus, plus one start pulse per instance.
  logic          start0  = 1'b0;
  logic          start1  = 1'b0;
  logic [AW-1:0] base    = '0;
  logic          s_valid = 1'b0;
  logic [31:0]   s_data  = '0;
  logic          s_last  = 1'b0;

  // Outputs of each instance.
  logic          rdy0, we0, crst0, busy0, done0, err0;
  logic          rdy1, we1, crst1, busy1, done1, err1;
  logic [AW-1:0] addr0, addr1;
  logic [31:0]   wd0, wd1, cs0, cs1;
  logic [AW:0]   wc0, wc1;

  imem_boot_loader #(
    .XLEN(32), .ADDR_W(AW), .FILL_ON_BOOT(1), .NOP_WORD(NOP)
  ) u_fill (
    .clk(clk), .rst(rst), .start(start0), .base_addr(base),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(rdy0),
    .im_we(we0), .im_addr(addr0), .im_wdata(wd0), .core_rst(crst0),
    .busy(busy0), .done(done0), .err(err0), .word_count(wc0), .checksum(cs0)
  );

  imem_boot_loader #(
    .XLEN(32), .ADDR_W(AW), .FILL_ON_BOOT(0), .NOP_WORD(NOP)
  ) u_nofill (
    .clk(clk), .rst(rst), .start(start1), .base_addr(base),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(rdy1),
    .im_we(we1), .im_addr(addr1), .im_wdata(wd1), .core_rst(crst1),
    .busy(busy1), .done(done1), .err(err1), .word_count(wc1), .checksum(cs1)
  );

  // The instance under test is chosen by sel; m_* are its outputs.
  int            sel = 0;
  logic          m_rdy, m_we, m_crst, m_busy, m_done, m_err;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wd, m_cs;
  logic [AW:0]   m_wc;

  always_comb begin
    if (sel == 0) begin
      m_rdy  = rdy0;  m_we   = we0;   m_crst = crst0; m_busy = busy0;
      m_done = done0; m_err  = err0;  m_addr = addr0; m_wd   = wd0;
      m_cs   = cs0;   m_wc   = wc0;
    end else begin
      m_rdy  = rdy1;  m_we   = we1;   m_crst = crst1; m_busy = busy1;
      m_done = done1; m_err  = err1;  m_addr = addr1; m_wd   = wd1;
      m_cs   = cs1;   m_wc   = wc1;
    end
  end

  // The IM each instance would see: apply every write-port beat.
  logic [31:0] mem_obs [2][DEPTH];

  always @(posedge clk) begin
    if (we0 === 1'b1) mem_obs[0][addr0] <= wd0;
    if (we1 === 1'b1) mem_obs[1][addr1] <= wd1;
  end

  // Reference model state.
  logic [31:0] exp_mem [2][DEPTH];
  bit          exp_v   [2][DEPTH];
  int          exp_wc;
  logic [31:0] exp_cs;
  bit          exp_err;

  logic [31:0] wq[$];
  bit          pat[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input bit v);
    if (sel == 0) start0 = v;
    else          start1 = v;
  endtask

  task automatic gen_words(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back($urandom);
  endtask

  // Model: the whole IM becomes NOP.
  task automatic model_fill();
    for (int a = 0; a < DEPTH; a++) begin
      exp_mem[sel][a] = NOP;
      exp_v[sel][a]   = 1'b1;
    end
  endtask

  // Model: words go to base, base+1, ... and stop at the last word or at
  // the top of IM, whichever comes first.
  task automatic model_load(input int b, input int n, input bit has_last);
    exp_wc  = 0;
    exp_cs  = '0;
    exp_err = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_mem[sel][b+i] = wq[i];
      exp_v[sel][b+i]   = 1'b1;
      exp_wc++;
      exp_cs = exp_cs + wq[i];
      if (has_last && i == n - 1) break;
      if (b + i == DEPTH - 1) begin
        exp_err = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_start(input int b);
    base = AW'(b);
    set_start(1'b1);
    tick();
    set_start(1'b0);
    chk("start_core_rst", m_crst, 1);
    chk("start_busy",     m_busy, 1);
    chk("start_done",     m_done, 0);
    chk("start_err",      m_err,  0);
    chk("start_wc",       m_wc,   0);
    chk("start_cs",       m_cs,   0);
  endtask

  // Checks every FILL beat; optionally pulses start at beat start_at.
  task automatic run_fill(input int start_at);
    bit ok = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (!(m_we === 1'b1 && m_addr === AW'(i) && m_wd === NOP &&
            m_rdy === 1'b0 && m_busy === 1'b1 && m_crst === 1'b1))
        ok = 1'b0;
      if (i == start_at) set_start(1'b1);
      tick();
      set_start(1'b0);
    end
    chk("fill_beats",    ok,    1);
    chk("fill_end_we",   m_we,  0);
    chk("fill_end_rdy",  m_rdy, 1);
    model_fill();
  endtask

  // Streams wq[0..n-1] and checks every write-port beat against the
  // handshakes, followed by the DRAIN and DONE cycles.
  task automatic run_load(input int b, input int n, input bit has_last,
                          input int start_cyc);
    int idx  = 0;
    int ptr  = b;
    int cyc  = 0;
    bit hs;
    bit term = 1'b0;

    chk("load_rdy", m_rdy, 1);
    while (idx < n && cyc < 500) begin
      s_data  = wq[idx];
      s_last  = has_last && (idx == n - 1);
      s_valid = (pat.size() > 0) ? pat[cyc % pat.size()]
                                 : ($urandom_range(0, 3) != 0);
      if (cyc == start_cyc) set_start(1'b1);
      hs = s_valid && (m_rdy === 1'b1);
      tick();
      set_start(1'b0);
      s_valid = 1'b0;
      chk("beat_we", m_we, hs);
      if (hs) begin
        chk("beat_addr",  m_addr, ptr);
        chk("beat_wdata", m_wd,   wq[idx]);
        term = s_last || (ptr == DEPTH - 1);
        idx++;
        ptr++;
        if (term) break;
      end
      cyc++;
    end

    chk("load_term", term, 1);
    s_last = 1'b0;

    // DRAIN: final write on the port, core still held.
    chk("drain_rdy",  m_rdy,  0);
    chk("drain_crst", m_crst, 1);
    chk("drain_busy", m_busy, 1);

    // Offer the leftover words; none may be taken.
    if (idx < n) begin
      s_valid = 1'b1;
      s_data  = wq[idx];
    end
    tick();

    // DONE: core released the cycle after the final write.
    chk("done_done", m_done, 1);
    chk("done_crst", m_crst, 0);
    chk("done_busy", m_busy, 0);
    chk("done_we",   m_we,   0);
    chk("done_rdy",  m_rdy,  0);
    if (idx < n) begin
      tick();
      chk("extra_we", m_we, 0);
    end
    s_valid = 1'b0;
  endtask

  task automatic check_result();
    int nm = 0;
    chk("wc",  m_wc,  exp_wc);
    chk("cs",  m_cs,  exp_cs);
    chk("err", m_err, exp_err);
    for (int a = 0; a < DEPTH; a++)
      if (exp_v[sel][a] && mem_obs[sel][a] !== exp_mem[sel][a]) nm++;
    chk("mem_mismatches", nm, 0);
  endtask

  initial begin
    bit idle_ok = 1'b1;
    int b;
    int n;

    for (int d = 0; d < 2; d++)
      for (int a = 0; a < DEPTH; a++) begin
        exp_v[d][a]   = 1'b0;
        exp_mem[d][a] = '0;
      end

    // Reset values of both instances.
    #2 rst = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      sel = d;
      #0;
      chk("rst_crst", m_crst, 1);
      chk("rst_we",   m_we,   0);
      chk("rst_addr", m_addr, 0);
      chk("rst_wd",   m_wd,   0);
      chk("rst_rdy",  m_rdy,  0);
      chk("rst_flags", {m_busy, m_done, m_err}, 0);
      chk("rst_wc",   m_wc,   0);
      chk("rst_cs",   m_cs,   0);
    end
    rst = 1'b0;

    // Released with no start: core held, no writes, stream ignored.
    for (int c = 0; c < 20; c++) begin
      s_valid = $urandom_range(0, 1) != 0;
      s_data  = $urandom;
      tick();
      if (!(crst0 === 1'b1 && crst1 === 1'b1 && we0 === 1'b0 && we1 === 1'b0 &&
            rdy0 === 1'b0 && rdy1 === 1'b0))
        idle_ok = 1'b0;
    end
    s_valid = 1'b0;
    chk("idle_quiet", idle_ok, 1);

    // Fill and load the reference program at base 0.
    // A start pulse during FILL is ignored.
    sel = 0;
    #0;
    wq.delete();
    wq.push_back(32'h0050_0093);
    wq.push_back(32'h00A0_0113);
    wq.push_back(32'h0020_81B3);
    wq.push_back(32'h0030_2023);
    wq.push_back(32'h0000_2283);
    do_start(0);
    chk("fill_first_we", m_we, 1);
    run_fill(100);
    run_load(0, 5, 1'b1, -1);
    model_load(0, 5, 1'b1);
    check_result();
    chk("prog_checksum", m_cs, 32'h0140_C5FF);

    // Restart from DONE; valid pattern 1,0,1,1,0,1; start during LOAD ignored.
    b = $urandom_range(0, 1000);
    gen_words(4);
    do_start(b);
    run_fill(-1);
    pat.delete();
    pat.push_back(1); pat.push_back(0); pat.push_back(1);
    pat.push_back(1); pat.push_back(0); pat.push_back(1);
    run_load(b, 4, 1'b1, 2);
    pat.delete();
    model_load(b, 4, 1'b1);
    check_result();

    // No fill, base 1020, six words with no last: truncated at the top.
    sel = 1;
    #0;
    gen_words(6);
    do_start(1020);
    chk("nofill_we", m_we, 0);
    run_load(1020, 6, 1'b0, -1);
    model_load(1020, 6, 1'b0);
    check_result();
    chk("ovf_err", m_err, 1);
    chk("ovf_wc",  m_wc,  4);

    // Random images at random bases; some run past the top of IM.
    for (int t = 0; t < 3; t++) begin
      b = $urandom_range(0, DEPTH - 1);
      n = $urandom_range(1, 20);
      gen_words(n);
      do_start(b);
      run_load(b, n, 1'b1, -1);
      model_load(b, n, 1'b1);
      check_result();
    end

    // Asynchronous reset in the middle of LOAD, then a full reload.
    sel = 0;
    #0;
    gen_words(5);
    do_start(0);
    run_fill(-1);
    s_valid = 1'b1;
    s_data  = wq[0];
    tick();
    chk("pre_abort_we", m_we, 1);
    s_data = wq[1];
    tick();
    s_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("abort_crst", m_crst, 1);
    chk("abort_we",   m_we,   0);
    chk("abort_rdy",  m_rdy,  0);
    chk("abort_busy", m_busy, 0);
    chk("abort_wc",   m_wc,   0);
    tick();
    rst = 1'b0;
    tick();
    chk("abort_idle_crst", m_crst, 1);
    gen_words(5);
    do_start(0);
    run_fill(-1);
    run_load(0, 5, 1'b1, -1);
    model_load(0, 5, 1'b1);
    check_result();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
